// File: rtl/bip_control_unit.sv
// Control unit for the BIP accumulator processor: program counter, instruction decode and run-state FSM.
// Optional branch instructions (JMP/BEQ/BNE) are compiled in with `define BIP_BRANCH_EN.
module bip_control_unit #(
    parameter int AB = 11,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_bip,
    input  logic [4:0]    OpCode,
    input  logic [AB-1:0] Operand,
    input  logic          acc_zero,
    output logic [AB-1:0] Addr,
    output logic [1:0]    SelA,
    output logic          SelB,
    output logic          WrAcc,
    output logic          Op,
    output logic          WrRam,
    output logic          RdRam,
    output logic          wr_uart,
    output logic          busy,
    output logic [CW-1:0] instr_count,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
`ifdef BIP_BRANCH_EN
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_BNE  = 5'b01010;
`endif

    state_t        state_q;
    state_t        state_d;
    logic [AB-1:0] addr_d;
    logic [AB-1:0] addr_inc;
    logic [CW-1:0] count_d;
    logic [CW-1:0] count_sat;

`ifndef BIP_BRANCH_EN
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{acc_zero, Operand};
`endif

    // Program counter wraps naturally at 2^AB; the counter sticks at its all-ones value.
    assign addr_inc  = Addr + 1'b1;
    assign count_sat = (&instr_count) ? instr_count : instr_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            Addr        <= '0;
            instr_count <= '0;
        end else begin
            state_q     <= state_d;
            Addr        <= addr_d;
            instr_count <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = Addr;
        count_d = instr_count;
        SelA    = 2'b00;
        SelB    = 1'b0;
        WrAcc   = 1'b0;
        Op      = 1'b0;
        WrRam   = 1'b0;
        RdRam   = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start_bip) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            ST_RUN: begin
                count_d = count_sat;
                addr_d  = addr_inc;
                case (OpCode)
                    OP_HLT: begin
                        addr_d  = Addr;
                        state_d = ST_DONE;
                    end
                    OP_STO: WrRam = 1'b1;
                    OP_LD: begin
                        WrAcc = 1'b1;
                        RdRam = 1'b1;
                    end
                    OP_LDI: begin
                        WrAcc = 1'b1;
                        SelA  = 2'b01;
                    end
                    OP_ADD, OP_SUB: begin
                        WrAcc = 1'b1;
                        RdRam = 1'b1;
                        SelA  = 2'b10;
                        Op    = OpCode[1];
                    end
                    OP_ADDI, OP_SUBI: begin
                        WrAcc = 1'b1;
                        SelA  = 2'b10;
                        SelB  = 1'b1;
                        Op    = OpCode[1];
                    end
`ifdef BIP_BRANCH_EN
                    OP_JMP: addr_d = Operand;
                    OP_BEQ: if (acc_zero) addr_d = Operand;
                    OP_BNE: if (!acc_zero) addr_d = Operand;
`endif
                    default: ;
                endcase
            end
            ST_DONE: state_d = ST_HALTED;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_uart   = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: three instances (default, AB=3 for PC wrap, CW=2 for count saturation)
// checked against a behavioural model, a decode vector table and hand-written corner sequences.
module tb_bip_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  start_v;
    logic        acc_zero;
    logic [4:0]  prog_op [2048];
    logic [10:0] prog_opnd [2048];

    // instance 0: AB=11, CW=16
    logic [10:0] a0;
    logic [1:0]  sa0, st0;
    logic        sb0, wa0, op0, wr0, rd0, wu0, bz0;
    logic [15:0] c0;
    logic [4:0]  opc0;
    logic [10:0] opn0;
    assign opc0 = prog_op[a0];
    assign opn0 = prog_opnd[a0];

    // instance 1: AB=3, CW=16
    logic [2:0]  a1;
    logic [1:0]  sa1, st1;
    logic        sb1, wa1, op1, wr1, rd1, wu1, bz1;
    logic [15:0] c1;
    logic [10:0] idx1;
    logic [4:0]  opc1;
    logic [10:0] opw1;
    logic [2:0]  opn1;
    assign idx1 = {8'b0, a1};
    assign opc1 = prog_op[idx1];
    assign opw1 = prog_opnd[idx1];
    assign opn1 = opw1[2:0];

    // instance 2: AB=11, CW=2
    logic [10:0] a2;
    logic [1:0]  sa2, st2;
    logic        sb2, wa2, op2, wr2, rd2, wu2, bz2;
    logic [1:0]  c2;
    logic [4:0]  opc2;
    logic [10:0] opn2;
    assign opc2 = prog_op[a2];
    assign opn2 = prog_opnd[a2];

    bip_control_unit #(.AB(11), .CW(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start_bip(start_v[0]), .OpCode(opc0), .Operand(opn0),
        .acc_zero(acc_zero), .Addr(a0), .SelA(sa0), .SelB(sb0), .WrAcc(wa0), .Op(op0),
        .WrRam(wr0), .RdRam(rd0), .wr_uart(wu0), .busy(bz0), .instr_count(c0), .state_dbg(st0));

    bip_control_unit #(.AB(3), .CW(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start_bip(start_v[1]), .OpCode(opc1), .Operand(opn1),
        .acc_zero(acc_zero), .Addr(a1), .SelA(sa1), .SelB(sb1), .WrAcc(wa1), .Op(op1),
        .WrRam(wr1), .RdRam(rd1), .wr_uart(wu1), .busy(bz1), .instr_count(c1), .state_dbg(st1));

    bip_control_unit #(.AB(11), .CW(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start_bip(start_v[2]), .OpCode(opc2), .Operand(opn2),
        .acc_zero(acc_zero), .Addr(a2), .SelA(sa2), .SelB(sb2), .WrAcc(wa2), .Op(op2),
        .WrRam(wr2), .RdRam(rd2), .wr_uart(wu2), .busy(bz2), .instr_count(c2), .state_dbg(st2));

    // Observation mux onto the instance currently under test.
    int          sel;
    logic [10:0] d_addr;
    logic [15:0] d_cnt;
    logic [6:0]  d_dec;
    logic        d_wu, d_bz;
    always_comb begin
        d_addr = a0;
        d_cnt  = c0;
        d_dec  = {sa0, sb0, wa0, op0, wr0, rd0};
        d_wu   = wu0;
        d_bz   = bz0;
        if (sel == 1) begin
            d_addr = {8'b0, a1};
            d_cnt  = c1;
            d_dec  = {sa1, sb1, wa1, op1, wr1, rd1};
            d_wu   = wu1;
            d_bz   = bz1;
        end else if (sel == 2) begin
            d_addr = a2;
            d_cnt  = {14'b0, c2};
            d_dec  = {sa2, sb2, wa2, op2, wr2, rd2};
            d_wu   = wu2;
            d_bz   = bz2;
        end
    end

    int n_pass = 0;
    int n_total = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model. Phases: 0 idle, 1 running, 2 completing, 3 halted.
    int m_phase = 0;
    int m_addr = 0;
    int m_cnt = 0;

    function automatic int addr_mod();
        return (sel == 1) ? 8 : 2048;
    endfunction

    function automatic int cnt_max();
        return (sel == 2) ? 3 : 65535;
    endfunction

    // Expected strobes packed as {SelA[1:0], SelB, WrAcc, Op, WrRam, RdRam}.
    function automatic logic [6:0] exp_dec(input logic [4:0] opc);
        case (opc)
            5'd1: return 7'b00_0_0_0_1_0;  // STO
            5'd2: return 7'b00_0_1_0_0_1;  // LD
            5'd3: return 7'b01_0_1_0_0_0;  // LDI
            5'd4: return 7'b10_0_1_0_0_1;  // ADD
            5'd5: return 7'b10_1_1_0_0_0;  // ADDI
            5'd6: return 7'b10_0_1_1_0_1;  // SUB
            5'd7: return 7'b10_1_1_1_0_0;  // SUBI
            default: return 7'b0;
        endcase
    endfunction

    // Entered at a falling edge; checks decode, then the state after the next rising edge.
    task automatic cycle(input logic st);
        int n_phase, n_addr, n_cnt, opc, tgt;
        start_v = 3'b0;
        start_v[sel] = st;
        #1;
        chk("decode", d_dec, (m_phase == 1) ? exp_dec(prog_op[m_addr]) : 7'b0);
        n_phase = m_phase;
        n_addr  = m_addr;
        n_cnt   = m_cnt;
        if ((m_phase == 0 || m_phase == 3) && st) begin
            n_phase = 1;
            n_addr  = 0;
            n_cnt   = 0;
        end else if (m_phase == 1) begin
            opc   = prog_op[m_addr];
            tgt   = prog_opnd[m_addr] % addr_mod();
            n_cnt = (m_cnt < cnt_max()) ? m_cnt + 1 : m_cnt;
            n_addr = (m_addr + 1) % addr_mod();
            if (opc == 0) begin
                n_phase = 2;
                n_addr  = m_addr;
            end
`ifdef BIP_BRANCH_EN
            if (opc == 8) n_addr = tgt;
            if (opc == 9 && acc_zero) n_addr = tgt;
            if (opc == 10 && !acc_zero) n_addr = tgt;
`endif
        end else if (m_phase == 2) begin
            n_phase = 3;
        end
        @(posedge clk);
        #1;
        m_phase = n_phase;
        m_addr  = n_addr;
        m_cnt   = n_cnt;
        chk("addr", d_addr, m_addr);
        chk("instr_count", d_cnt, m_cnt);
        chk("busy", d_bz, m_phase == 1);
        chk("wr_uart", d_wu, m_phase == 2);
        if (d_wu) pulses++;
        @(negedge clk);
    endtask

    // Asserts reset between clock edges and checks that it takes effect without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", d_addr, 0);
        chk("rst_count", d_cnt, 0);
        chk("rst_busy", d_bz, 0);
        chk("rst_wr_uart", d_wu, 0);
        m_phase = 0;
        m_addr  = 0;
        m_cnt   = 0;
        start_v = 3'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) begin
            prog_op[i]   = 5'd31;
            prog_opnd[i] = 11'd0;
        end
    endtask

    task automatic load_demo();
        clear_prog();
        prog_op[0] = 5'd3; prog_opnd[0] = 11'd5;
        prog_op[1] = 5'd5; prog_opnd[1] = 11'd3;
        prog_op[2] = 5'd1; prog_opnd[2] = 11'd7;
        prog_op[3] = 5'd0;
    endtask

    typedef struct {
        logic [4:0] opc;
        logic [6:0] dec;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd2,  7'b0001001};
        vecs[1] = '{5'd3,  7'b0101000};
        vecs[2] = '{5'd1,  7'b0000010};
        vecs[3] = '{5'd4,  7'b1001001};
        vecs[4] = '{5'd5,  7'b1011000};
        vecs[5] = '{5'd6,  7'b1001101};
        vecs[6] = '{5'd7,  7'b1011100};
        vecs[7] = '{5'd11, 7'b0000000};
        vecs[8] = '{5'd16, 7'b0000000};
        vecs[9] = '{5'd31, 7'b0000000};

        sel = 0;
        acc_zero = 1'b0;
        start_v = 3'b0;
        clear_prog();
        repeat (2) @(negedge clk);
        chk("reset_addr", d_addr, 0);
        chk("reset_count", d_cnt, 0);
        chk("reset_busy", d_bz, 0);
        chk("reset_wr_uart", d_wu, 0);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0);

        // Demo program: LDI 5, ADDI 3, STO 7, HLT.
        load_demo();
        pulses = 0;
        cycle(1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0);
        chk("demo_count", d_cnt, 4);
        chk("demo_pulses", pulses, 1);
        chk("demo_busy", d_bz, 0);
        chk("demo_addr", d_addr, 3);

        // Decode table.
        async_reset();
        clear_prog();
        foreach (vecs[i]) prog_op[i] = vecs[i].opc;
        prog_op[10] = 5'd0;
        cycle(1'b1);
        foreach (vecs[i]) begin
            chk("tbl_addr", d_addr, i);
            chk("tbl_dec", d_dec, vecs[i].dec);
            cycle(1'b0);
        end
        repeat (3) cycle(1'b0);
        chk("tbl_count", d_cnt, 11);

        // Program counter wrap with AB=3: HLT appears at 0 after the first pass.
        sel = 1;
        async_reset();
        clear_prog();
        cycle(1'b1);
        cycle(1'b0);
        prog_op[0] = 5'd0;
        repeat (10) cycle(1'b0);
        chk("wrap_count", d_cnt, 9);
        chk("wrap_addr", d_addr, 0);
        chk("wrap_busy", d_bz, 0);

        // Counter saturation with CW=2.
        sel = 2;
        async_reset();
        clear_prog();
        prog_op[4] = 5'd0;
        cycle(1'b1);
        repeat (7) cycle(1'b0);
        chk("sat_count", d_cnt, 3);
        chk("sat_addr", d_addr, 4);

        // start_bip held high: no restart before HLT, restart from 0 once halted.
        sel = 0;
        async_reset();
        load_demo();
        repeat (7) cycle(1'b1);
        chk("hold_busy", d_bz, 1);
        chk("hold_addr", d_addr, 0);
        chk("hold_count", d_cnt, 0);
        repeat (3) cycle(1'b1);

        // Reset mid-run, then reset while completing.
        async_reset();
        clear_prog();
        pulses = 0;
        cycle(1'b1);
        repeat (2) cycle(1'b0);
        chk("mid_addr", d_addr, 2);
        async_reset();
        chk("mid_pulses", pulses, 0);
        repeat (2) cycle(1'b0);
        cycle(1'b1);
        repeat (3) cycle(1'b0);
        chk("rerun_addr", d_addr, 3);
        async_reset();
        load_demo();
        cycle(1'b1);
        repeat (4) cycle(1'b0);
        chk("done_wr_uart", d_wu, 1);
        async_reset();

        // Opcode 01001 at 0 with target 6: branch when enabled, NOP otherwise.
        clear_prog();
        prog_op[0] = 5'd9; prog_opnd[0] = 11'd6;
        acc_zero = 1'b1;
        cycle(1'b1);
        cycle(1'b0);
`ifdef BIP_BRANCH_EN
        chk("beq_taken", d_addr, 6);
`else
        chk("beq_nop", d_addr, 1);
`endif
        async_reset();
        acc_zero = 1'b0;
        cycle(1'b1);
        cycle(1'b0);
        chk("beq_not_taken", d_addr, 1);
        async_reset();
        prog_op[0] = 5'd8; prog_opnd[0] = 11'd0;
        cycle(1'b1);
        repeat (10) cycle(1'b0);
`ifdef BIP_BRANCH_EN
        chk("jmp_loop", d_addr, 0);
`else
        chk("jmp_nop", d_addr, 10);
`endif
        chk("jmp_busy", d_bz, 1);

        // Randomized programs, start requests and acc_zero.
        for (int r = 0; r < 20; r++) begin
            async_reset();
            clear_prog();
            for (int i = 0; i < 64; i++) begin
                prog_op[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                prog_opnd[i] = 11'($urandom_range(0, 63));
            end
            cycle(1'b1);
            for (int c = 0; c < 40; c++) begin
                acc_zero = 1'($urandom_range(0, 1));
                cycle($urandom_range(0, 3) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
